// File: rtl/muu_pkg.sv
// muu_pkg: shared constants for the MUU response path.
// Opcodes, descriptor field offsets and FSM encoding.
package muu_pkg;

   localparam logic [3:0] OP_IGNORE    = 4'd0;
   localparam logic [3:0] OP_GET       = 4'd1;
   localparam logic [3:0] OP_SET       = 4'd2;
   localparam logic [3:0] OP_SETNEXT   = 4'd3;
   localparam logic [3:0] OP_DELCUR    = 4'd4;
   localparam logic [3:0] OP_FLIPPOINT = 4'd5;
   localparam logic [3:0] OP_GETRAW    = 4'd6;
   localparam logic [3:0] OP_FLUSH     = 4'd7;

   // Opcode nibble sits in the top byte of the meta field.
   localparam int OPC_META_OFF     = 88;
   localparam int OPC_W            = 4;
   localparam int VALPOINT_HDR_OFF = 0;
   localparam int VALPOINT_W       = 32;
   localparam int VALLEN_HDR_OFF   = 32;
   localparam int VALLEN_W         = 16;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HEADER = 2'd1;
   localparam logic [1:0] ST_VALUE  = 2'd2;

   function automatic logic is_read(input logic [3:0] op,
                                    input logic [15:0] len);
      return ((op == OP_GET) || (op == OP_GETRAW)) && (len != 16'd0);
   endfunction

endpackage

// File: rtl/muu_last_mask.sv
// muu_last_mask: keep-mask for the final value beat.
// r = 0 keeps every word; otherwise 64-bit words r..7 are cleared.
module muu_last_mask #(
   parameter int WIDTH = 512
) (
   input  logic [2:0]       r,
   output logic [WIDTH-1:0] keep
);

   localparam int WORDS = WIDTH / 64;

   always_comb begin
      keep = '0;
      for (int i = 0; i < WORDS; i++) begin
         if ((r == 3'd0) || (i < int'(r))) begin
            keep[64*i +: 64] = '1;
         end
      end
   end

endmodule

// File: rtl/muu_value_get.sv
// muu_value_get: frames one response per retired descriptor,
// a header beat followed by masked memory value beats.
module muu_value_get
   import muu_pkg::*;
#(
   parameter int KEY_WIDTH    = 64,
   parameter int HEADER_WIDTH = 48,
   parameter int META_WIDTH   = 96,
   parameter int MEMORY_WIDTH = 512
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [KEY_WIDTH+META_WIDTH+HEADER_WIDTH-1:0] input_data,
   input  logic                                      input_valid,
   output logic                                      input_ready,
   input  logic [MEMORY_WIDTH-1:0]                   rddata_data,
   input  logic                                      rddata_valid,
   output logic                                      rddata_ready,
   output logic [MEMORY_WIDTH-1:0]                   output_data,
   output logic                                      output_valid,
   output logic                                      output_last,
   input  logic                                      output_ready,
   output logic [31:0]                               resp_count
);

   localparam int DW       = KEY_WIDTH + META_WIDTH + HEADER_WIDTH;
   localparam int OPC_LSB  = KEY_WIDTH + OPC_META_OFF;
   localparam int VLEN_LSB = KEY_WIDTH + META_WIDTH + VALLEN_HDR_OFF;

   logic [1:0]              state;
   logic [DW-1:0]           desc;
   logic                    rd_q;
   logic [13:0]             count;

   logic                    out_free;
   logic                    in_fire;
   logic                    rd_fire;
   logic [3:0]              opc_in;
   logic [15:0]             vallen_in;
   logic                    rd_in;
   logic [13:0]             beats_in;
   logic                    last_beat;
   logic [MEMORY_WIDTH-1:0] keep;
   logic [MEMORY_WIDTH-1:0] hdr_beat;
   logic [MEMORY_WIDTH-1:0] val_beat;

   assign out_free = !output_valid || output_ready;

   assign input_ready  = !rst && (state == ST_IDLE) && out_free;
   assign rddata_ready = !rst && (state == ST_VALUE) && out_free;

   assign in_fire = input_valid && input_ready;
   assign rd_fire = rddata_valid && rddata_ready;

   assign opc_in    = input_data[OPC_LSB +: OPC_W];
   assign vallen_in = input_data[VLEN_LSB +: VALLEN_W];
   assign rd_in     = is_read(opc_in, vallen_in);

   // ceil(vallen/8) without a wide adder; tops out at 8192
   assign beats_in = {1'b0, vallen_in[15:3]}
                   + {13'd0, |vallen_in[2:0]};

   assign last_beat = (count == 14'd1);

   muu_last_mask #(
      .WIDTH(MEMORY_WIDTH)
   ) u_mask (
      .r    (desc[VLEN_LSB +: 3]),
      .keep (keep)
   );

   always_comb begin
      hdr_beat         = '0;
      hdr_beat[DW-1:0] = desc;
   end

   assign val_beat = last_beat ? (rddata_data & keep) : rddata_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         desc         <= '0;
         rd_q         <= 1'b0;
         count        <= '0;
         output_data  <= '0;
         output_valid <= 1'b0;
         output_last  <= 1'b0;
         resp_count   <= '0;
      end else begin
         if (output_valid && output_ready) begin
            output_valid <= 1'b0;
         end
         unique case (state)
            ST_IDLE: begin
               if (in_fire) begin
                  desc  <= input_data;
                  rd_q  <= rd_in;
                  count <= rd_in ? beats_in : 14'd0;
                  state <= ST_HEADER;
               end
            end
            ST_HEADER: begin
               if (out_free) begin
                  output_data  <= hdr_beat;
                  output_valid <= 1'b1;
                  output_last  <= !rd_q;
                  if (rd_q) begin
                     state <= ST_VALUE;
                  end else begin
                     state      <= ST_IDLE;
                     resp_count <= resp_count + 32'd1;
                  end
               end
            end
            ST_VALUE: begin
               if (rd_fire) begin
                  output_data  <= val_beat;
                  output_valid <= 1'b1;
                  output_last  <= last_beat;
                  count        <= count - 14'd1;
                  if (last_beat) begin
                     state      <= ST_IDLE;
                     resp_count <= resp_count + 32'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muu_value_get.sv
// tb_muu_value_get: table-driven and hand-sequenced checks of the
// response framer against a scoreboard of expected output beats.
module tb_muu_value_get;

   localparam int DW      = 208;
   localparam int MW      = 512;
   localparam int OPC_LSB = 152;
   localparam int VL_LSB  = 192;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] input_data;
   logic          input_valid;
   logic          input_ready;
   logic [MW-1:0] rddata_data;
   logic          rddata_valid;
   logic          rddata_ready;
   logic [MW-1:0] output_data;
   logic          output_valid;
   logic          output_last;
   logic          output_ready;
   logic [31:0]   resp_count;

   muu_value_get dut (
      .clk          (clk),
      .rst          (rst),
      .input_data   (input_data),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .rddata_data  (rddata_data),
      .rddata_valid (rddata_valid),
      .rddata_ready (rddata_ready),
      .output_data  (output_data),
      .output_valid (output_valid),
      .output_last  (output_last),
      .output_ready (output_ready),
      .resp_count   (resp_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] vl;
      logic [7:0]  fill;
      int          mode;
      int          vbeats;
   } vec_t;

   logic [MW:0]   exp_q[$];
   logic [MW-1:0] mem_q[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            rdy_mode = 0;
   int            obs_beats = 0;
   bit            rd_seen = 0;
   int            exp_resp = 0;
   logic [MW-1:0] stray_data;
   vec_t          tbl[12];

   function automatic void chk(input string nm, input logic [MW-1:0] act,
                               input logic [MW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   function automatic logic [MW-1:0] rand_beat(input logic [7:0] fill);
      logic [MW-1:0] b;
      for (int k = 0; k < MW / 32; k++) b[32*k +: 32] = $urandom();
      if (fill != 8'd0) b = {(MW/8){fill}};
      return b;
   endfunction

   // output_ready pattern: 0 always, 1 toggling, 2 random
   initial begin
      output_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            1:       output_ready = ~output_ready;
            2:       output_ready = 1'($urandom_range(0, 1));
            default: output_ready = 1'b1;
         endcase
      end
   end

   // memory beat source, holds each beat until accepted
   initial begin
      bit fire;
      rddata_valid = 1'b0;
      rddata_data  = '0;
      forever begin
         @(negedge clk);
         fire = rddata_valid && rddata_ready && !rst;
         @(posedge clk); #1;
         if (fire && mem_q.size() > 0) void'(mem_q.pop_front());
         if (mem_q.size() > 0) begin
            rddata_valid = 1'b1;
            rddata_data  = mem_q[0];
         end else begin
            rddata_valid = 1'b0;
         end
      end
   end

   // output monitor: compares beats, checks stability under stall
   initial begin
      bit            held = 0;
      logic [MW-1:0] hd;
      logic          hl;
      logic [MW:0]   e;
      forever begin
         @(negedge clk);
         if (!rst && rddata_ready) rd_seen = 1;
         if (!rst && output_valid) begin
            if (held) begin
               chk("stable_data", output_data, hd);
               chk("stable_last", MW'(output_last), MW'(hl));
            end
            if (output_ready) begin
               held = 0;
               obs_beats++;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL beat: unexpected last=%0b data=%0h",
                           output_last, output_data);
               end else begin
                  e = exp_q.pop_front();
                  if ({output_last, output_data} !== e) begin
                     n_err++;
                     $display("FAIL beat: got last=%0b %0h want last=%0b %0h",
                              output_last, output_data, e[MW], e[MW-1:0]);
                  end
               end
            end else begin
               held = 1;
               hd   = output_data;
               hl   = output_last;
            end
         end else begin
            held = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // builds descriptor, queues memory beats and expected output beats
   task automatic prep(input logic [3:0] op, input logic [15:0] vl,
                       input logic [7:0] fill, input bit use_stray,
                       output logic [DW-1:0] d, output logic [MW-1:0] b0);
      logic [MW-1:0] b;
      logic [2:0]    r;
      bit            rd;
      int            nb;
      d = DW'({$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom()});
      d[OPC_LSB +: 4] = op;
      d[VL_LSB +: 16] = vl;
      rd = ((op == 4'd1) || (op == 4'd6)) && (vl != 16'd0);
      nb = rd ? (int'(vl) + 7) / 8 : 0;
      r  = vl[2:0];
      b0 = '0;
      exp_q.push_back({!rd, MW'(d)});
      for (int i = 0; i < nb; i++) begin
         if (use_stray && i == 0) b = stray_data;
         else begin
            b = rand_beat(fill);
            mem_q.push_back(b);
         end
         if (i == 0) b0 = b;
         if (i == nb - 1 && r != 3'd0) begin
            for (int w = 0; w < 8; w++)
               if (w >= int'(r)) b[64*w +: 64] = '0;
         end
         exp_q.push_back({(i == nb - 1), b});
      end
   endtask

   task automatic send_desc(input logic [DW-1:0] d, input string nm);
      int n = 0;
      input_data  = d;
      input_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!input_ready && n < 500);
      if (!input_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_accept: descriptor not taken in %0d cycles", nm, n);
      end
      @(posedge clk); #1;
      input_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_done: %0d beats outstanding, want 0", nm,
                  exp_q.size());
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic run_txn(input vec_t v, input bit use_stray,
                          input string nm);
      logic [DW-1:0] d;
      logic [MW-1:0] b0;
      bit            rd;
      rdy_mode  = v.mode;
      rd        = ((v.op == 4'd1) || (v.op == 4'd6)) && (v.vl != 16'd0);
      prep(v.op, v.vl, v.fill, use_stray, d, b0);
      obs_beats = 0;
      rd_seen   = 0;
      send_desc(d, nm);
      wait_done(nm);
      exp_resp++;
      chk({nm, "_beats"}, MW'(obs_beats), MW'(v.vbeats + 1));
      chk({nm, "_resp"}, MW'(resp_count), MW'(exp_resp));
      if (!rd) chk({nm, "_rdready"}, MW'(rd_seen), MW'(0));
   endtask

   initial begin
      logic [DW-1:0] d;
      logic [MW-1:0] b0;
      vec_t          v;
      int            n;

      tbl[0]  = '{4'd2, 16'd16, 8'h00, 0, 0};
      tbl[1]  = '{4'd1, 16'd8, 8'hAA, 0, 1};
      tbl[2]  = '{4'd1, 16'd11, 8'h00, 0, 2};
      tbl[3]  = '{4'd1, 16'd24, 8'h00, 1, 3};
      tbl[4]  = '{4'd6, 16'd64, 8'h00, 2, 8};
      tbl[5]  = '{4'd1, 16'd0, 8'h00, 0, 0};
      tbl[6]  = '{4'd7, 16'd5, 8'h00, 0, 0};
      tbl[7]  = '{4'd6, 16'd1, 8'h00, 1, 1};
      tbl[8]  = '{4'd1, 16'd63, 8'h00, 2, 8};
      tbl[9]  = '{4'd0, 16'd40, 8'h00, 0, 0};
      tbl[10] = '{4'd4, 16'd8, 8'h00, 0, 0};
      tbl[11] = '{4'd1, 16'd65, 8'h00, 1, 9};

      rst         = 1'b1;
      input_valid = 1'b0;
      input_data  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", MW'(input_ready), MW'(0));
      chk("rst_rd_ready", MW'(rddata_ready), MW'(0));
      chk("rst_valid", MW'(output_valid), MW'(0));
      chk("rst_last", MW'(output_last), MW'(0));
      chk("rst_data", output_data, '0);
      chk("rst_count", MW'(resp_count), MW'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_txn(tbl[i], 0, $sformatf("vec%0d", i));
      end

      // latency: header two cycles after accept, first value beat next
      rdy_mode = 0;
      repeat (2) @(posedge clk); #1;
      prep(4'd1, 16'd16, 8'h00, 0, d, b0);
      obs_beats = 0;
      send_desc(d, "lat");
      @(negedge clk);
      chk("lat_t1_valid", MW'(output_valid), MW'(0));
      @(negedge clk);
      chk("lat_t2_valid", MW'(output_valid), MW'(1));
      chk("lat_t2_hdr", output_data, MW'(d));
      @(negedge clk);
      chk("lat_t3_valid", MW'(output_valid), MW'(1));
      chk("lat_t3_data", output_data, b0);
      wait_done("lat");
      exp_resp++;
      chk("lat_resp", MW'(resp_count), MW'(exp_resp));

      // stray memory beat waits through a header-only response
      stray_data = rand_beat(8'h00);
      mem_q.push_back(stray_data);
      repeat (3) @(posedge clk); #1;
      v = '{4'd2, 16'd32, 8'h00, 0, 0};
      run_txn(v, 0, "stray_set");
      chk("stray_pending", MW'(rddata_valid), MW'(1));
      v = '{4'd1, 16'd8, 8'h00, 0, 1};
      run_txn(v, 1, "stray_get");

      // largest value length: 8192 beats, final beat keeps words 0..6
      v = '{4'd1, 16'hFFFF, 8'h00, 0, 8192};
      run_txn(v, 0, "max");

      // reset part-way through a 4-beat read
      rdy_mode = 1;
      prep(4'd1, 16'd32, 8'h00, 0, d, b0);
      obs_beats = 0;
      send_desc(d, "mid");
      n = 0;
      while (obs_beats < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("mid_progress", MW'(obs_beats >= 2), MW'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      mem_q.delete();
      @(posedge clk);
      @(negedge clk);
      chk("mid_valid", MW'(output_valid), MW'(0));
      chk("mid_last", MW'(output_last), MW'(0));
      chk("mid_data", output_data, '0);
      chk("mid_count", MW'(resp_count), MW'(0));
      chk("mid_rd_ready", MW'(rddata_ready), MW'(0));
      @(posedge clk); #1;
      rst      = 1'b0;
      exp_resp = 0;
      v = '{4'd1, 16'd30, 8'h00, 2, 4};
      run_txn(v, 0, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
